// File: rtl/uio_handshake_tx.sv
// ============================================================================
// Module   : uio_handshake_tx
// Brief    : FIFO-buffered byte transmitter onto bidirectional pads using a
//            four-phase tx_req/rx_ack handshake. Optional macro
//            UIO_TX_TIMEOUT_EN adds a REQ/REL watchdog with a sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uio_handshake_tx #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       tx_req,
  input  logic       rx_ack,
  output logic       busy,
  output logic       err
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    setup_cnt_q, setup_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ack_s1_q, ack_s1_d;
  logic          ack_s2_q, ack_s2_d;
  logic [7:0]    mem_q [DEPTH];

  logic pop;
  logic wr_en;
  logic empty;
  logic full;
  logic timeout;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  // A pop frees a slot on the same edge, so a write is taken even when full.
  assign wr_en = in_valid && (!full || pop);

`ifdef UIO_TX_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  always_comb begin
    tmo_cnt_d = 8'd0;
    timeout   = 1'b0;
    if (state_q == REQ || state_q == REL) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
      timeout   = (tmo_cnt_q == 8'd254);
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    setup_cnt_d = setup_cnt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          data_d      = mem_q[rd_ptr_q];
          setup_cnt_d = 4'd0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d = REQ;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      REQ: begin
        if (ack_s2_q) begin
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s2_q) begin
          if (!empty) begin
            pop         = 1'b1;
            data_d      = mem_q[rd_ptr_q];
            setup_cnt_d = 4'd0;
            state_d     = SETUP;
          end else begin
            data_d  = 8'h00;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (timeout) begin
      pop     = 1'b0;
      data_d  = 8'h00;
      state_d = IDLE;
    end
  end

  always_comb begin
    ack_s1_d = rx_ack;
    ack_s2_d = ack_s1_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= 8'h00;
      setup_cnt_q <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_s1_q    <= 1'b0;
      ack_s2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      setup_cnt_q <= setup_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ack_s1_q    <= ack_s1_d;
      ack_s2_q    <= ack_s2_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready = !full;
  assign uio_oe   = (state_q == IDLE) ? 8'h00 : 8'hFF;
  assign uio_out  = (state_q == IDLE) ? 8'h00 : data_q;
  assign tx_req   = (state_q == REQ);
  assign busy     = !empty || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uio_handshake_tx.sv
// ============================================================================
// Module   : tb_uio_handshake_tx
// Brief    : Scoreboard bench: stimulus queues expected bytes, a monitor
//            checks each byte presented with a tx_req rise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uio_handshake_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       tx_req;
  logic       rx_ack;
  logic       busy;
  logic       err;

  logic ack_m;
  logic ack_pulse;
  logic ack_en;
  bit   no_release_chk;
  int   n_cmp;
  int   n_bad;
  logic [7:0] exp_q[$];

  assign rx_ack = ack_m | ack_pulse;

  always #5 clk = ~clk;

  uio_handshake_tx #(.DEPTH(4), .SETUP_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .tx_req   (tx_req),
    .rx_ack   (rx_ack),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_req rise must present the next expected byte.
  initial begin
    logic       prev;
    logic [7:0] held;
    logic [7:0] e;
    prev = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (tx_req && !prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_transfer: got byte %0h expected none", uio_out);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", uio_out, e);
            check("oe_in_req", uio_oe, 8'hFF);
          end
          held = uio_out;
        end else if (!tx_req && prev && !no_release_chk) begin
          check("held_at_release", uio_out, held);
        end
        prev = tx_req;
      end
    end
  end

  // Receiver: acks 3 sampled cycles after tx_req, drops ack once tx_req falls.
  initial begin
    int cnt;
    cnt   = 0;
    ack_m = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_m = 1'b0;
        cnt   = 0;
      end else if (ack_m) begin
        if (!tx_req) ack_m = 1'b0;
      end else if (ack_en && tx_req) begin
        cnt++;
        if (cnt >= 3) begin
          ack_m = 1'b1;
          cnt   = 0;
        end
      end
    end
  end

  task automatic wait_req(input string name);
    for (int i = 0; i < 50 && !tx_req; i++) @(negedge clk);
    check(name, tx_req, 1'b1);
  endtask

  task automatic wait_fall(input string name);
    for (int i = 0; i < 50 && tx_req; i++) @(negedge clk);
    check(name, tx_req, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && uio_oe == 8'h00 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, done, 1'b1);
  endtask

  task automatic single_xfer(input logic [7:0] b, input bit pulse);
    int n;
    exp_q.push_back(b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pulse && n == 1) ack_pulse = 1'b1;
      if (n == 2) begin
        ack_pulse = 1'b0;
        check("setup_oe", uio_oe, 8'hFF);
        check("setup_out", uio_out, b);
        check("setup_req_low", tx_req, 1'b0);
      end
      if (tx_req) break;
    end
    check("req_latency", n, 4);
    wait_idle("xfer_done");
    check("release_oe", uio_oe, 8'h00);
    check("release_out", uio_out, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_data        = 8'h00;
    ack_en         = 1'b0;
    ack_pulse      = 1'b0;
    no_release_chk = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_oe", uio_oe, 8'h00);
    check("rst_out", uio_out, 8'h00);
    rst = 1'b0;

    // Single transfer with loopback ack, then one with a SETUP-time ack pulse.
    ack_en = 1'b1;
    single_xfer(8'hA5, 1'b0);
    single_xfer(8'h3C, 1'b1);

    // Hold 8'h10 in REQ, then overfill the FIFO: 8'h15 must be dropped.
    ack_en = 1'b0;
    exp_q.push_back(8'h10);
    @(negedge clk);
    in_data  = 8'h10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_req("b0_req");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k > 1) check("in_ready_fill", in_ready, ((k - 1) < 4) ? 1'b1 : 1'b0);
      in_data  = 8'h10 + 8'(k);
      in_valid = 1'b1;
      if (k <= 4) exp_q.push_back(8'h10 + 8'(k));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_full", in_ready, 1'b0);
    check("busy_full", busy, 1'b1);

    // Resume acks; hold a write so it lands on the REL->SETUP pop edge.
    ack_en = 1'b1;
    wait_fall("b0_fall");
    in_data  = 8'h5A;
    in_valid = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("full_before_pop", in_ready, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("full_after_pop_write", in_ready, 1'b0);
    wait_idle("fill_drain");

`ifdef UIO_TX_TIMEOUT_EN
    // Stuck ack: first byte times out after 255 REQ cycles, second proceeds.
    begin
      int hi;
      ack_en = 1'b0;
      no_release_chk = 1'b1;
      exp_q.push_back(8'hD0);
      exp_q.push_back(8'hD1);
      @(negedge clk);
      in_data  = 8'hD0;
      in_valid = 1'b1;
      @(negedge clk);
      in_data  = 8'hD1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_req("tmo_req");
      hi = 0;
      while (tx_req && hi < 400) begin
        hi++;
        @(negedge clk);
      end
      check("tmo_req_cycles", hi, 255);
      check("tmo_err", err, 1'b1);
      @(negedge clk);
      no_release_chk = 1'b0;
      ack_en = 1'b1;
      wait_idle("tmo_next_byte");
      check("tmo_err_sticky", err, 1'b1);
    end
`endif

    // Reset while in REQ with two bytes queued: nothing else may transfer.
    ack_en = 1'b0;
    exp_q.push_back(8'hC0);
    @(negedge clk);
    in_data  = 8'hC0;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = 8'hC1;
    @(negedge clk);
    in_data  = 8'hC2;
    @(negedge clk);
    in_valid = 1'b0;
    wait_req("c0_req");
    no_release_chk = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_req", tx_req, 1'b0);
    check("mid_rst_oe", uio_oe, 8'h00);
    check("mid_rst_out", uio_out, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_err", err, 1'b0);
    ack_en = 1'b1;
    repeat (30) @(negedge clk);
    no_release_chk = 1'b0;
    check("post_rst_idle_req", tx_req, 1'b0);
    check("post_rst_idle_busy", busy, 1'b0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
